dial_move_parser: RTL and testbench



---
 rtl/dial_pkg.sv | 30 +++
 rtl/dec_accum.sv | 41 ++++
 rtl/dial_move_parser.sv | 152 +++++++++++++++
 tb/tb_dial_move_parser.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dial_pkg.sv
// Shared constants and types for the dial-rotation front end.
package dial_pkg;

  localparam int unsigned DIST_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGITS,
    ST_SKIP,
    ST_ISSUE,
    ST_HOLD,
    ST_DONE
  } parse_state_e;

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Saturating decimal accumulator: acc = acc*10 + digit, clamped to all-ones.
module dec_accum #(
  parameter int unsigned DIST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [3:0]        digit,
  output logic [DIST_W-1:0] acc,
  output logic [DIST_W-1:0] acc_next_c,
  output logic              has_digit,
  output logic              ovf_c
);

  localparam int unsigned WIDE_W = DIST_W + 4;
  localparam logic [WIDE_W-1:0] ACC_MAX = WIDE_W'({DIST_W{1'b1}});

  logic [WIDE_W-1:0] wide_c;

  // ovf_c flags that accepting the presented digit would saturate.
  always_comb begin
    wide_c     = (WIDE_W'(acc) << 3) + (WIDE_W'(acc) << 1) + WIDE_W'(digit);
    ovf_c      = (wide_c > ACC_MAX);
    acc_next_c = ovf_c ? {DIST_W{1'b1}} : wide_c[DIST_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      has_digit <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      has_digit <= 1'b0;
    end else if (en) begin
      acc       <= acc_next_c;
      has_digit <= 1'b1;
    end
  end

endmodule

// File: rtl/dial_move_parser.sv
// Parses "L68\n"-style ASCII lines into valid/ready move requests for the dial sequencer.
module dial_move_parser
  import dial_pkg::*;
#(
  parameter int unsigned DIST_W = DIST_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              move_valid,
  output logic              move_direction,
  output logic [DIST_W-1:0] move_distance,
  input  logic              move_ready,
  output logic [CNT_W-1:0]  moves_issued,
  output logic              err_syntax,
  output logic              err_overflow,
  output logic              done
);

  parse_state_e      state, state_d;
  logic              pend_last, pend_last_d;
  logic              in_ready_d, move_valid_d, dir_d, done_d;
  logic              err_syn_d, err_ovf_d;
  logic [DIST_W-1:0] dist_d;
  logic [CNT_W-1:0]  cnt_d;

  logic              acc_clear_c, acc_en_c, xfer_c;
  logic [DIST_W-1:0] acc, acc_next_c;
  logic              has_digit, ovf_c;

  dec_accum #(.DIST_W(DIST_W)) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (acc_clear_c),
    .en         (acc_en_c),
    .digit      (in_data[3:0]),
    .acc        (acc),
    .acc_next_c (acc_next_c),
    .has_digit  (has_digit),
    .ovf_c      (ovf_c)
  );

  assign xfer_c = in_valid && in_ready;

  // Next-state and next-output logic; an in_last byte ends the stream after any move it completes.
  always_comb begin
    state_d     = state;
    pend_last_d = pend_last | (xfer_c & in_last);
    dir_d       = move_direction;
    dist_d      = move_distance;
    cnt_d       = moves_issued;
    err_syn_d   = err_syntax;
    err_ovf_d   = err_overflow;
    acc_clear_c = 1'b0;
    acc_en_c    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (xfer_c) begin
          if (in_data == CH_L || in_data == CH_R) begin
            dir_d       = (in_data == CH_R) ? DIR_RIGHT : DIR_LEFT;
            acc_clear_c = 1'b1;
            if (in_last) begin
              err_syn_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              state_d = ST_DIGITS;
            end
          end else if (in_data == CH_NL || in_data == CH_CR) begin
            if (in_last) state_d = ST_DONE;
          end else begin
            err_syn_d = 1'b1;
            state_d   = in_last ? ST_DONE : ST_SKIP;
          end
        end
      end
      ST_DIGITS: begin
        if (xfer_c) begin
          if (is_digit(in_data)) begin
            acc_en_c = 1'b1;
            if (ovf_c) err_ovf_d = 1'b1;
            if (in_last) begin
              dist_d  = acc_next_c;
              state_d = ST_ISSUE;
            end
          end else if (in_data == CH_NL || (in_data == CH_CR && in_last)) begin
            if (has_digit) begin
              dist_d  = acc;
              state_d = ST_ISSUE;
            end else begin
              err_syn_d = 1'b1;
              state_d   = in_last ? ST_DONE : ST_IDLE;
            end
          end else if (in_data != CH_CR) begin
            err_syn_d = 1'b1;
            state_d   = in_last ? ST_DONE : ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        if (xfer_c) begin
          if (in_last)               state_d = ST_DONE;
          else if (in_data == CH_NL) state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (move_valid && move_ready) begin
          cnt_d   = moves_issued + CNT_W'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: state_d = pend_last ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_DIGITS) || (state_d == ST_SKIP);
    move_valid_d = (state_d == ST_ISSUE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pend_last      <= 1'b0;
      in_ready       <= 1'b1;
      move_valid     <= 1'b0;
      move_direction <= DIR_LEFT;
      move_distance  <= '0;
      moves_issued   <= '0;
      err_syntax     <= 1'b0;
      err_overflow   <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_d;
      pend_last      <= pend_last_d;
      in_ready       <= in_ready_d;
      move_valid     <= move_valid_d;
      move_direction <= dir_d;
      move_distance  <= dist_d;
      moves_issued   <= cnt_d;
      err_syntax     <= err_syn_d;
      err_overflow   <= err_ovf_d;
      done           <= done_d;
    end
  end

endmodule

// File: tb/tb_dial_move_parser.sv
// Directed self-checking bench for dial_move_parser.
module tb_dial_move_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        move_valid;
  logic        move_direction;
  logic [15:0] move_distance;
  logic        move_ready = 1'b0;
  logic [15:0] moves_issued;
  logic        err_syntax;
  logic        err_overflow;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic        xdir_q[$];
  logic [15:0] xdist_q[$];
  logic        hdir_q[$];
  logic [15:0] hdist_q[$];
  bit          hold_pend = 1'b0;

  always #5 clk = ~clk;

  dial_move_parser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .move_valid     (move_valid),
    .move_direction (move_direction),
    .move_distance  (move_distance),
    .move_ready     (move_ready),
    .moves_issued   (moves_issued),
    .err_syntax     (err_syntax),
    .err_overflow   (err_overflow),
    .done           (done)
  );

  // Log each transfer and the direction/distance seen in the cycle after it.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        hdir_q.push_back(move_direction);
        hdist_q.push_back(move_distance);
        hold_pend = 1'b0;
      end
      if (move_valid && move_ready) begin
        xdir_q.push_back(move_direction);
        xdist_q.push_back(move_distance);
        hold_pend = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    xdir_q.delete(); xdist_q.delete(); hdir_q.delete(); hdist_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; move_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = b; in_last = last;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte %h not accepted, in_ready=%b required 1", b, in_ready);
    end
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, move_valid, move_direction, move_distance, moves_issued, err_syntax, err_overflow, done}
        !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b mv=%b dir=%b dist=%0d cnt=%0d es=%b eo=%b done=%b required 1 0 0 0 0 0 0 0",
               in_ready, move_valid, move_direction, move_distance, moves_issued, err_syntax, err_overflow, done);
    end
  endtask

  task automatic test_single_move();
    do_reset();
    move_ready = 1'b1;
    send_str("R48\n", 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (xdist_q.size() != 1 || xdir_q[0] !== 1'b1 || xdist_q[0] !== 16'd48) begin
      errors++;
      $display("FAIL single_xfer: got n=%0d dir=%b dist=%0d required n=1 dir=1 dist=48", xdist_q.size(), xdir_q[0], xdist_q[0]);
    end
    checks++;
    if (hdist_q.size() != 1 || hdir_q[0] !== 1'b1 || hdist_q[0] !== 16'd48) begin
      errors++;
      $display("FAIL single_hold: got n=%0d dir=%b dist=%0d required n=1 dir=1 dist=48", hdist_q.size(), hdir_q[0], hdist_q[0]);
    end
    checks++;
    if ({moves_issued, err_syntax, err_overflow, done, in_ready} !== {16'd1, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL single_status: got cnt=%0d es=%b eo=%b done=%b rdy=%b required 1 0 0 0 1",
               moves_issued, err_syntax, err_overflow, done, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_dir[3];
    logic [15:0] exp_dist[3];
    exp_dir  = '{1'b0, 1'b0, 1'b1};
    exp_dist = '{16'd68, 16'd30, 16'd48};
    do_reset();
    move_ready = 1'b1;
    send_str("L68\nL30\n", 1'b0);
    send_str("R48\n", 1'b1);
    @(negedge clk);
    checks++;
    if (move_valid !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_issue: got mv=%b done=%b required mv=1 done=0", move_valid, done);
    end
    @(negedge clk);
    checks++;
    if (move_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: got mv=%b done=%b required mv=0 done=0", move_valid, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got done=%b rdy=%b required done=1 rdy=0", done, in_ready);
    end
    checks++;
    if (xdist_q.size() != 3 || moves_issued !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count: got n=%0d cnt=%0d required 3 3", xdist_q.size(), moves_issued);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (xdir_q[i] !== exp_dir[i] || xdist_q[i] !== exp_dist[i]) begin
        errors++;
        $display("FAIL b2b_move%0d: got dir=%b dist=%0d required dir=%b dist=%0d", i, xdir_q[i], xdist_q[i], exp_dir[i], exp_dist[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    move_ready = 1'b0;
    send_str("R7", 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (move_valid !== 1'b1 || move_distance !== 16'd7 || move_direction !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got mv=%b dir=%b dist=%0d rdy=%b required 1 1 7 0", c, move_valid, move_direction, move_distance, in_ready);
      end
    end
    checks++;
    if (xdist_q.size() != 0 || moves_issued !== 16'd0) begin
      errors++;
      $display("FAIL bp_no_xfer: got n=%0d cnt=%0d required 0 0", xdist_q.size(), moves_issued);
    end
    @(posedge clk);
    #1 move_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || moves_issued !== 16'd1 || xdist_q.size() != 1 || xdist_q[0] !== 16'd7) begin
      errors++;
      $display("FAIL bp_release: got done=%b cnt=%0d n=%0d dist=%0d required 1 1 1 7", done, moves_issued, xdist_q.size(), xdist_q[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    move_ready = 1'b1;
    send_str("L65536\n", 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (err_overflow !== 1'b1 || err_syntax !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag: got eo=%b es=%b required eo=1 es=0", err_overflow, err_syntax);
    end
    checks++;
    if (xdist_q.size() != 1 || xdir_q[0] !== 1'b0 || xdist_q[0] !== 16'hFFFF || moves_issued !== 16'd1) begin
      errors++;
      $display("FAIL ovf_xfer: got n=%0d dir=%b dist=%h cnt=%0d required 1 0 ffff 1", xdist_q.size(), xdir_q[0], xdist_q[0], moves_issued);
    end
  endtask

  task automatic test_syntax();
    do_reset();
    move_ready = 1'b1;
    send_str("X12\nR\nR5\r\n", 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (err_syntax !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL syn_flag: got es=%b eo=%b required es=1 eo=0", err_syntax, err_overflow);
    end
    checks++;
    if (xdist_q.size() != 1 || xdir_q[0] !== 1'b1 || xdist_q[0] !== 16'd5 || moves_issued !== 16'd1) begin
      errors++;
      $display("FAIL syn_xfer: got n=%0d dir=%b dist=%0d cnt=%0d required 1 1 5 1", xdist_q.size(), xdir_q[0], xdist_q[0], moves_issued);
    end
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    move_ready = 1'b0;
    send_str("R9\n", 1'b0);
    @(negedge clk);
    checks++;
    if (move_valid !== 1'b1 || move_direction !== 1'b1 || move_distance !== 16'd9) begin
      errors++;
      $display("FAIL rst_pre: got mv=%b dir=%b dist=%0d required 1 1 9", move_valid, move_direction, move_distance);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, move_valid, move_direction, move_distance, moves_issued, err_syntax, err_overflow, done}
        !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL rst_async: got rdy=%b mv=%b dir=%b dist=%0d cnt=%0d es=%b eo=%b done=%b required 1 0 0 0 0 0 0 0",
               in_ready, move_valid, move_direction, move_distance, moves_issued, err_syntax, err_overflow, done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    move_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (xdist_q.size() != 0 || moves_issued !== 16'd0 || move_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_dropped: got n=%0d cnt=%0d mv=%b required 0 0 0", xdist_q.size(), moves_issued, move_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_syntax();
    test_reset_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
